// File: rtl/pipe_hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_scoreboard_if
// Bundle between the pipeline decode/execute logic and the hazard scoreboard.
//   master : pipeline side. Drives the ID-stage instruction description and
//            ex_redirect, and receives stall/flush/forward/bypass/counter.
//   slave  : scoreboard side (pipe_hazard_scoreboard). Direction mirrored.
// Signals:
//   id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_en, id_wr_reg,
//   id_is_load : instruction currently in ID
//   ex_redirect : taken branch/jump resolved in EX
//   stall, flush_if_id, flush_id_ex : pipeline control
//   fwd_a, fwd_b : EX operand source select (0 = ID/EX value, k = stage k)
//   rf_bypass_a, rf_bypass_b : ID register read takes the WB write data
//   stall_cnt : saturating stall-cycle counter
// ---------------------------------------------------------------------------
interface pipe_hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int FW     = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_reg;
  logic              id_is_load;
  logic              ex_redirect;
  logic              stall;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic              rf_bypass_a;
  logic              rf_bypass_b;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wr_en, id_wr_reg, id_is_load, ex_redirect,
    input  stall, flush_if_id, flush_id_ex, fwd_a, fwd_b,
           rf_bypass_a, rf_bypass_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wr_en, id_wr_reg, id_is_load, ex_redirect,
    output stall, flush_if_id, flush_id_ex, fwd_a, fwd_b,
           rf_bypass_a, rf_bypass_b, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_hazard_scoreboard
// Hazard and forwarding controller for the in-order MIPS pipeline. A shift
// register holds one {valid, wr, reg, load} entry per stage after ID
// (entry 0 = EX, entry DEPTH-1 = WB). Matching the ID source operands against
// it yields the load-use / WB stall, the flushes on redirect and the EX
// forward selects, which are registered at issue so they are valid while the
// instruction sits in EX.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : pipe_hazard_scoreboard_if.slave (ID instruction in, controls out)
// Optional feature macro: PIPE_HAZARD_RF_BYPASS_EN
//   defined   : a WB-stage match asserts rf_bypass_a/b instead of stalling
//   undefined : rf_bypass_a/b are 0 and a WB-stage match stalls one cycle
// ---------------------------------------------------------------------------
module pipe_hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int FW         = $clog2(DEPTH),
  parameter int CNT_W      = 16
) (
  input logic                     clk,
  input logic                     reset,
  pipe_hazard_scoreboard_if.slave bus
);

  logic [DEPTH-1:0]  ent_valid_q;
  logic [DEPTH-1:0]  ent_wr_q;
  logic [DEPTH-1:0]  ent_load_q;
  logic [REG_AW-1:0] ent_reg_q [DEPTH];

  logic [DEPTH-1:0]  match_a_s;
  logic [DEPTH-1:0]  match_b_s;
  logic              load_hz_s;
  logic              stall_s;
  logic              issue_s;
  logic              byp_a_s;
  logic              byp_b_s;

  logic              ent0_valid_d;
  logic              ent0_wr_d;
  logic              ent0_load_d;
  logic [REG_AW-1:0] ent0_reg_d;

  logic [FW-1:0]     fwd_a_d, fwd_a_q;
  logic [FW-1:0]     fwd_b_d, fwd_b_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

  // Operand-vs-entry matching and load-use hazard detection.
  always_comb begin
    match_a_s = {DEPTH{1'b0}};
    match_b_s = {DEPTH{1'b0}};
    load_hz_s = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      // Register 0 is hard-wired zero, so it never creates a dependency.
      match_a_s[j] = ent_valid_q[j] & ent_wr_q[j] &
                     (ent_reg_q[j] != {REG_AW{1'b0}}) &
                     (ent_reg_q[j] == bus.id_rs) & bus.id_rs_used;
      match_b_s[j] = ent_valid_q[j] & ent_wr_q[j] &
                     (ent_reg_q[j] != {REG_AW{1'b0}}) &
                     (ent_reg_q[j] == bus.id_rt) & bus.id_rt_used;
    end
    // Loads younger than LOAD_STAGE have no data yet, so nothing can forward.
    for (int j = 0; j < LOAD_STAGE; j++) begin
      load_hz_s = load_hz_s | (ent_load_q[j] & (match_a_s[j] | match_b_s[j]));
    end
  end

`ifdef PIPE_HAZARD_RF_BYPASS_EN
  // WB match is served by the register-file write-data bypass, no stall.
  always_comb begin
    byp_a_s = bus.id_valid & match_a_s[DEPTH-1];
    byp_b_s = bus.id_valid & match_b_s[DEPTH-1];
    stall_s = bus.id_valid & ~bus.ex_redirect & load_hz_s;
  end
`else
  // WB match stalls: RF write and read share the cycle without a bypass.
  always_comb begin
    byp_a_s = 1'b0;
    byp_b_s = 1'b0;
    stall_s = bus.id_valid & ~bus.ex_redirect &
              (load_hz_s | match_a_s[DEPTH-1] | match_b_s[DEPTH-1]);
  end
`endif

  // Issue decision, new EX entry, forward selects and counter next state.
  always_comb begin
    issue_s      = bus.id_valid & ~stall_s & ~bus.ex_redirect;
    ent0_valid_d = issue_s;
    ent0_wr_d    = issue_s & bus.id_wr_en;
    ent0_load_d  = issue_s & bus.id_is_load;
    ent0_reg_d   = issue_s ? bus.id_wr_reg : {REG_AW{1'b0}};
    fwd_a_d      = {FW{1'b0}};
    fwd_b_d      = {FW{1'b0}};
    if (issue_s) begin
      // Scan oldest to youngest so the youngest producer overwrites last.
      for (int j = DEPTH - 2; j >= 0; j--) begin
        fwd_a_d = match_a_s[j] ? FW'(j + 1) : fwd_a_d;
        fwd_b_d = match_b_s[j] ? FW'(j + 1) : fwd_b_d;
      end
    end else begin
      fwd_a_d = {FW{1'b0}};
      fwd_b_d = {FW{1'b0}};
    end
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Scoreboard shift register, forward-select and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid_q <= {DEPTH{1'b0}};
      ent_wr_q    <= {DEPTH{1'b0}};
      ent_load_q  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg_q[i] <= {REG_AW{1'b0}};
      end
      fwd_a_q     <= {FW{1'b0}};
      fwd_b_q     <= {FW{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ent_valid_q <= {ent_valid_q[DEPTH-2:0], ent0_valid_d};
      ent_wr_q    <= {ent_wr_q[DEPTH-2:0], ent0_wr_d};
      ent_load_q  <= {ent_load_q[DEPTH-2:0], ent0_load_d};
      for (int i = 1; i < DEPTH; i++) begin
        ent_reg_q[i] <= ent_reg_q[i-1];
      end
      ent_reg_q[0] <= ent0_reg_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.stall       = stall_s;
  assign bus.flush_if_id = bus.ex_redirect;
  assign bus.flush_id_ex = bus.ex_redirect;
  assign bus.fwd_a       = fwd_a_q;
  assign bus.fwd_b       = fwd_b_q;
  assign bus.rf_bypass_a = byp_a_s;
  assign bus.rf_bypass_b = byp_b_s;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_scoreboard
// Directed instruction sequences for pipe_hazard_scoreboard (DEPTH=3,
// LOAD_STAGE=1). Each stimulus cycle pushes the hand-computed expected
// outputs into a queue; an independent monitor pops and compares them a few
// ns after every clock edge. Honors PIPE_HAZARD_RF_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_scoreboard;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard_if #(.REG_AW(5), .FW(2), .CNT_W(16)) bus ();

  pipe_hazard_scoreboard #(
    .REG_AW(5), .DEPTH(3), .LOAD_STAGE(1), .FW(2), .CNT_W(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

`ifdef PIPE_HAZARD_RF_BYPASS_EN
  localparam int WBS = 0;
`else
  localparam int WBS = 1;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
    logic       wen;
    logic [4:0] wreg;
    logic       ld;
    logic       rd;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        ba;
    logic        bb;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   rec_n = 0;

  function automatic stim_t ins(input int v, input int rs, input int rt,
                                input int rsu, input int rtu, input int wen,
                                input int wreg, input int ld, input int rd);
    stim_t s;
    s.v = v[0]; s.rs = rs[4:0]; s.rt = rt[4:0]; s.rsu = rsu[0]; s.rtu = rtu[0];
    s.wen = wen[0]; s.wreg = wreg[4:0]; s.ld = ld[0]; s.rd = rd[0];
    return s;
  endfunction

  function automatic exp_t ex(input int st, input int fl, input int fa,
                              input int fb, input int ba, input int bb,
                              input int cnt);
    exp_t e;
    e.stall = st[0]; e.flush = fl[0]; e.fa = fa[1:0]; e.fb = fb[1:0];
    e.ba = ba[0]; e.bb = bb[0]; e.cnt = cnt[15:0];
    return e;
  endfunction

  task automatic drive(input stim_t s);
    bus.id_valid    = s.v;
    bus.id_rs       = s.rs;
    bus.id_rt       = s.rt;
    bus.id_rs_used  = s.rsu;
    bus.id_rt_used  = s.rtu;
    bus.id_wr_en    = s.wen;
    bus.id_wr_reg   = s.wreg;
    bus.id_is_load  = s.ld;
    bus.ex_redirect = s.rd;
  endtask

  task automatic cyc(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    drive(s);
    q.push_back(e);
  endtask

  task automatic idle(input int n, input int cnt);
    for (int i = 0; i < n; i++) begin
      cyc(ins(0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, cnt));
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s rec%0d: got %0d want %0d", name, rec_n, got, want);
    end
  endtask

  // Monitor: compare the oldest expected record 4 ns after each clock edge.
  always @(clk) begin
    #4;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("stall", int'(bus.stall), int'(mon_e.stall));
      chk("flush_if_id", int'(bus.flush_if_id), int'(mon_e.flush));
      chk("flush_id_ex", int'(bus.flush_id_ex), int'(mon_e.flush));
      chk("fwd_a", int'(bus.fwd_a), int'(mon_e.fa));
      chk("fwd_b", int'(bus.fwd_b), int'(mon_e.fb));
      chk("rf_bypass_a", int'(bus.rf_bypass_a), int'(mon_e.ba));
      chk("rf_bypass_b", int'(bus.rf_bypass_b), int'(mon_e.bb));
      chk("stall_cnt", int'(bus.stall_cnt), int'(mon_e.cnt));
      rec_n++;
    end
  end

  stim_t bub;
  stim_t cons;

  initial begin
    bub = ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    drive(bub);
    // Reset state.
    @(posedge clk);
    #1;
    q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    #5;
    reset = 1'b1;
    idle(2, 0);

    // add $3,$1,$2 ; sub $4,$3,$5 -> fwd_a = 1 for sub
    cyc(ins(1, 1, 2, 1, 1, 1, 3, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
    cyc(ins(1, 3, 5, 1, 1, 1, 4, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
    cyc(bub, ex(0, 0, 1, 0, 0, 0, 0));
    idle(3, 0);

    // add $3 ; nop ; or $6,$3,$3 -> fwd_a = fwd_b = 2
    cyc(ins(1, 1, 2, 1, 1, 1, 3, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
    cyc(bub, ex(0, 0, 0, 0, 0, 0, 0));
    cyc(ins(1, 3, 3, 1, 1, 1, 6, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
    cyc(bub, ex(0, 0, 2, 2, 0, 0, 0));
    idle(3, 0);

    // lw $8,0($0) ; add $9,$8,$1 -> one stall cycle, then fwd_a = 2
    cyc(ins(1, 0, 8, 1, 0, 1, 8, 1, 0), ex(0, 0, 0, 0, 0, 0, 0));
    cyc(ins(1, 8, 1, 1, 1, 1, 9, 0, 0), ex(1, 0, 0, 0, 0, 0, 0));
    cyc(ins(1, 8, 1, 1, 1, 1, 9, 0, 0), ex(0, 0, 0, 0, 0, 0, 1));
    cyc(bub, ex(0, 0, 2, 0, 0, 0, 1));
    idle(3, 1);

    // addi $0,$0,5 ; add $2,$0,$0 -> register 0 never hazards/forwards
    cyc(ins(1, 0, 0, 1, 0, 1, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 1));
    cyc(ins(1, 0, 0, 1, 1, 1, 2, 0, 0), ex(0, 0, 0, 0, 0, 0, 1));
    cyc(bub, ex(0, 0, 0, 0, 0, 0, 1));
    idle(3, 1);

    // lw $8 in EX, lw $10,0($8) in ID with redirect -> flush, no stall,
    // entry 0 bubble: following add $11,$10,$8 neither stalls nor sees $10
    cyc(ins(1, 0, 8, 1, 0, 1, 8, 1, 0), ex(0, 0, 0, 0, 0, 0, 1));
    cyc(ins(1, 8, 10, 1, 0, 1, 10, 1, 1), ex(0, 1, 0, 0, 0, 0, 1));
    cyc(ins(1, 10, 8, 1, 1, 1, 11, 0, 0), ex(0, 0, 0, 0, 0, 0, 1));
    cyc(bub, ex(0, 0, 0, 2, 0, 0, 1));
    idle(3, 1);

    // Producer in WB while consumer in ID
    cons = ins(1, 3, 4, 1, 1, 1, 5, 0, 0);
    cyc(ins(1, 1, 2, 1, 1, 1, 3, 0, 0), ex(0, 0, 0, 0, 0, 0, 1));
    cyc(bub, ex(0, 0, 0, 0, 0, 0, 1));
    cyc(bub, ex(0, 0, 0, 0, 0, 0, 1));
    cyc(cons, ex(WBS, 0, 0, 0, 1 - WBS, 0, 1));
`ifdef PIPE_HAZARD_RF_BYPASS_EN
    cyc(bub, ex(0, 0, 0, 0, 0, 0, 1));
`else
    cyc(cons, ex(0, 0, 0, 0, 0, 0, 2));
    cyc(bub, ex(0, 0, 0, 0, 0, 0, 2));
`endif
    idle(3, 1 + WBS);

    // Reset asserted in the middle of a load-use stall
    cyc(ins(1, 1, 2, 1, 1, 1, 3, 0, 0), ex(0, 0, 0, 0, 0, 0, 1 + WBS));
    cyc(ins(1, 3, 0, 1, 0, 1, 8, 1, 0), ex(0, 0, 0, 0, 0, 0, 1 + WBS));
    cyc(ins(1, 8, 1, 1, 1, 1, 9, 0, 0), ex(1, 0, 1, 0, 0, 0, 1 + WBS));
    #5;
    reset = 1'b0;
    q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    cyc(bub, ex(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    cyc(ins(1, 8, 1, 1, 1, 1, 9, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
    cyc(bub, ex(0, 0, 0, 0, 0, 0, 0));

    // Drain the scoreboard queue within a bounded number of cycles.
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
      #6;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d records left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
